// File: rtl/keccak_absorb_ctrl.sv
// ============================================================================
// Module   : keccak_absorb_ctrl
// Purpose  : Absorbs padded 64-bit lanes into a Keccak-f[1600] state, runs an
//            external permutation core per block, then squeezes digest lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_absorb_ctrl #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [LANE_W-1:0]             in_lane,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          perm_start,
  output logic [LANE_W*NUM_LANES-1:0]   state_out,
  input  logic                          perm_done,
  input  logic [LANE_W*NUM_LANES-1:0]   perm_state_in,
  output logic [LANE_W-1:0]             digest_out,
  output logic                          digest_valid,
  input  logic                          digest_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int STATE_W = LANE_W * NUM_LANES;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ABSORB    = 2'd1,
    ST_PERM_WAIT = 2'd2,
    ST_SQUEEZE   = 2'd3
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [4:0]          lane_cnt_q, lane_cnt_d;
  logic [4:0]          out_cnt_q, out_cnt_d;
  logic                last_flag_q, last_flag_d;
  logic [1:0]          mode_q, mode_d;
  logic                perm_start_q, perm_start_d;
  logic                digest_valid_q, digest_valid_d;
  logic [LANE_W-1:0]   digest_out_q, digest_out_d;
  logic                done_q, done_d;

  logic [4:0]          rate;
  logic [4:0]          out_len;
  logic                accept;

  // Lane selector; written as a compare loop so the index never overflows.
  function automatic logic [LANE_W-1:0] lane_of(input logic [STATE_W-1:0] s,
                                                input logic [4:0] idx);
    lane_of = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == 5'(i)) lane_of = s[i*LANE_W +: LANE_W];
    end
  endfunction

  // Rate and digest length in lanes for the latched mode.
  always_comb begin
    case (mode_q)
      2'd1:    begin rate = 5'd9;  out_len = 5'd8; end
      2'd2:    begin rate = 5'd21; out_len = 5'd4; end
      default: begin rate = 5'd17; out_len = 5'd4; end
    endcase
  end

  assign in_ready     = (fsm_q == ST_ABSORB);
  assign accept       = in_valid & in_ready;
  assign busy         = (fsm_q != ST_IDLE);
  assign state_out    = state_q;
  assign perm_start   = perm_start_q;
  assign digest_out   = digest_out_q;
  assign digest_valid = digest_valid_q;
  assign done         = done_q;

  // Next-state logic for the controller and all datapath registers.
  always_comb begin
    fsm_d          = fsm_q;
    state_d        = state_q;
    lane_cnt_d     = lane_cnt_q;
    out_cnt_d      = out_cnt_q;
    last_flag_d    = last_flag_q;
    mode_d         = mode_q;
    perm_start_d   = 1'b0;
    digest_valid_d = digest_valid_q;
    digest_out_d   = digest_out_q;
    done_d         = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          state_d     = '0;
          lane_cnt_d  = 5'd0;
          last_flag_d = 1'b0;
          fsm_d       = ST_ABSORB;
        end
      end

      ST_ABSORB: begin
        if (accept) begin
          // lane_cnt never reaches rate, so capacity lanes stay untouched.
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_cnt_q == 5'(i)) begin
              state_d[i*LANE_W +: LANE_W] = state_q[i*LANE_W +: LANE_W] ^ in_lane;
            end
          end
          last_flag_d = last_flag_q | in_last;
          if (lane_cnt_q == rate - 5'd1) begin
            lane_cnt_d   = 5'd0;
            perm_start_d = 1'b1;
            fsm_d        = ST_PERM_WAIT;
          end else begin
            lane_cnt_d = lane_cnt_q + 5'd1;
          end
        end
      end

      ST_PERM_WAIT: begin
        if (perm_done) begin
          state_d = perm_state_in;
          if (last_flag_q) begin
            out_cnt_d      = 5'd0;
            digest_valid_d = 1'b1;
            digest_out_d   = lane_of(perm_state_in, 5'd0);
            fsm_d          = ST_SQUEEZE;
          end else begin
            fsm_d = ST_ABSORB;
          end
        end
      end

      ST_SQUEEZE: begin
        if (digest_ready) begin
          if (out_cnt_q == out_len - 5'd1) begin
            digest_valid_d = 1'b0;
            done_d         = 1'b1;
            fsm_d          = ST_IDLE;
          end else begin
            out_cnt_d    = out_cnt_q + 5'd1;
            digest_out_d = lane_of(state_q, out_cnt_q + 5'd1);
          end
        end
      end

      default: fsm_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any block or permutation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q          <= ST_IDLE;
      state_q        <= '0;
      lane_cnt_q     <= 5'd0;
      out_cnt_q      <= 5'd0;
      last_flag_q    <= 1'b0;
      mode_q         <= 2'd0;
      perm_start_q   <= 1'b0;
      digest_valid_q <= 1'b0;
      digest_out_q   <= '0;
      done_q         <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      state_q        <= state_d;
      lane_cnt_q     <= lane_cnt_d;
      out_cnt_q      <= out_cnt_d;
      last_flag_q    <= last_flag_d;
      mode_q         <= mode_d;
      perm_start_q   <= perm_start_d;
      digest_valid_q <= digest_valid_d;
      digest_out_q   <= digest_out_d;
      done_q         <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keccak_absorb_ctrl.sv
// ============================================================================
// Module   : tb_keccak_absorb_ctrl
// Purpose  : Directed self-checking bench for keccak_absorb_ctrl with an
//            identity permutation stub driven inline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keccak_absorb_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [63:0]   in_lane;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          perm_start;
  logic [1599:0] state_out;
  logic          perm_done;
  logic [1599:0] perm_state_in;
  logic [63:0]   digest_out;
  logic          digest_valid;
  logic          digest_ready;
  logic          busy;
  logic          done;

  int            n_cmp = 0;
  int            n_err = 0;
  int            ps_cnt = 0;
  int            ps0;
  logic [63:0]   exp_dig [8];
  logic [1599:0] st_snap;

  keccak_absorb_ctrl #(.LANE_W(64), .NUM_LANES(25)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .in_lane      (in_lane),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .perm_start   (perm_start),
    .state_out    (state_out),
    .perm_done    (perm_done),
    .perm_state_in(perm_state_in),
    .digest_out   (digest_out),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Count perm_start pulses seen at clock edges.
  always @(posedge clk) if (perm_start) ps_cnt <= ps_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ln(input int i);
    return state_out[i*64 +: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds n lanes starting at the current negedge (FSM in ABSORB).
  task automatic absorb(input int n, input logic [63:0] base, input bit incr,
                        input int last_idx, input bit gaps);
    int   n_acc;
    logic rdy_all;
    n_acc   = 0;
    rdy_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        rdy_all  = rdy_all & in_ready;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_lane  = incr ? base + 64'(k) : base;
      in_last  = (k == last_idx);
      rdy_all  = rdy_all & in_ready;
      if (in_ready) n_acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept_count", 64'(n_acc), 64'(n));
    if (gaps) chk("ready_through_gaps", {63'd0, rdy_all}, 64'd1);
  endtask

  // Identity permutation stub; called on the perm_start negedge.
  task automatic do_perm();
    st_snap = state_out;
    @(negedge clk);
    chk("perm_start_single", {63'd0, perm_start}, 64'd0);
    @(negedge clk);
    perm_done     = 1'b1;
    perm_state_in = st_snap;
    @(negedge clk);
    perm_done     = 1'b0;
  endtask

  task automatic squeeze(input int n, input int stall_idx);
    for (int j = 0; j < n; j++) begin
      chk("dig_valid", {63'd0, digest_valid}, 64'd1);
      chk("dig_lane", digest_out, exp_dig[j]);
      if (j == stall_idx) begin
        digest_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk("stall_hold", digest_out, exp_dig[j]);
          chk("stall_valid", {63'd0, digest_valid}, 64'd1);
        end
      end
      digest_ready = 1'b1;
      @(negedge clk);
    end
    digest_ready = 1'b0;
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("valid_drop", {63'd0, digest_valid}, 64'd0);
    @(negedge clk);
    chk("done_once", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; in_lane = '0; in_valid = 1'b0;
    in_last = 1'b0; perm_done = 1'b0; perm_state_in = '0; digest_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_digest_valid", {63'd0, digest_valid}, 64'd0);
    chk("rst_state", {63'd0, |state_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of ABSORB after 5 lanes
    do_start(2'd1);
    absorb(5, 64'h1, 1'b1, -1, 1'b0);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    chk("mid_lane4", ln(4), 64'h5);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_state", {63'd0, |state_out}, 64'd0);
    chk("abort_perm_start", {63'd0, perm_start}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_digest_out", digest_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mode 1: 9 lanes 1..9, squeeze 8 lanes with a stall on lane 2
    ps0 = ps_cnt;
    do_start(2'd1);
    absorb(9, 64'h1, 1'b1, 8, 1'b0);
    chk("m1_perm_start", {63'd0, perm_start}, 64'd1);
    chk("m1_in_ready_wait", {63'd0, in_ready}, 64'd0);
    chk("m1_lane0", ln(0), 64'h1);
    chk("m1_lane8", ln(8), 64'h9);
    chk("m1_lane9", ln(9), 64'h0);
    do_perm();
    for (int j = 0; j < 8; j++) exp_dig[j] = 64'(j + 1);
    squeeze(8, 2);
    chk("m1_perm_count", 64'(ps_cnt - ps0), 64'd1);

    // mode 0: two identical blocks cancel
    ps0 = ps_cnt;
    do_start(2'd0);
    absorb(17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 1'b0);
    chk("m0_perm_start1", {63'd0, perm_start}, 64'd1);
    chk("m0_lane16", ln(16), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("m0_lane17", ln(17), 64'h0);
    do_perm();
    chk("m0_back_absorb", {63'd0, in_ready}, 64'd1);
    absorb(17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);
    chk("m0_perm_start2", {63'd0, perm_start}, 64'd1);
    do_perm();
    for (int j = 0; j < 4; j++) exp_dig[j] = 64'h0;
    squeeze(4, -1);
    chk("m0_perm_count", 64'(ps_cnt - ps0), 64'd2);

    // mode 2: 21 lanes with gaps, capacity untouched
    do_start(2'd2);
    absorb(21, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 0, 1'b1);
    chk("m2_perm_start", {63'd0, perm_start}, 64'd1);
    chk("m2_lane20", ln(20), 64'hA5A5_A5A5_A5A5_A5A5);
    chk("m2_capacity", {63'd0, |state_out[1599:1344]}, 64'd0);
    do_perm();
    for (int j = 0; j < 4; j++) exp_dig[j] = 64'hA5A5_A5A5_A5A5_A5A5;
    squeeze(4, -1);

    // Spurious start/perm_done in ABSORB, in_valid in PERM_WAIT
    do_start(2'd1);
    absorb(3, 64'h1, 1'b1, -1, 1'b0);
    start = 1'b1; mode = 2'd2; perm_done = 1'b1; perm_state_in = '1;
    @(negedge clk);
    start = 1'b0; perm_done = 1'b0; perm_state_in = '0;
    chk("sp_in_ready", {63'd0, in_ready}, 64'd1);
    chk("sp_lane0", ln(0), 64'h1);
    chk("sp_lane3", ln(3), 64'h0);
    chk("sp_perm_start", {63'd0, perm_start}, 64'd0);
    absorb(6, 64'h4, 1'b1, 5, 1'b0);
    chk("sp_perm_start_rate9", {63'd0, perm_start}, 64'd1);
    chk("sp_lane8", ln(8), 64'h9);
    st_snap = state_out;
    in_valid = 1'b1; in_lane = 64'hDEAD_BEEF_0000_0001; in_last = 1'b1;
    @(negedge clk);
    chk("pw_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("pw_state_hold", {63'd0, state_out === st_snap}, 64'd1);
    in_valid = 1'b0; in_last = 1'b0;
    perm_done = 1'b1; perm_state_in = st_snap;
    @(negedge clk);
    perm_done = 1'b0;
    for (int j = 0; j < 8; j++) exp_dig[j] = 64'(j + 1);
    squeeze(8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
